mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arbiter_if.sv | 58 +++++
 rtl/mem_arb_starve_ctr.sv | 33 +++
 rtl/mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the memory arbiter: FSM state encoding,
// access-width codes and the project-wide width constants.
package mem_arbiter_pkg;

    localparam int AddressWidth = 32;
    localparam int IDWidth      = 4;

    // Arbiter states, 2-bit encoded.
    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_INST_BUSY = 2'd1,
        ARB_DATA_BUSY = 2'd2,
        ARB_RECOVER   = 2'd3
    } arb_state_t;

    // Data access width codes (one-hot byte count).
    localparam logic [2:0] WIDTH_B = 3'b001;
    localparam logic [2:0] WIDTH_H = 3'b010;
    localparam logic [2:0] WIDTH_W = 3'b100;

    // True while a transfer is in flight on the controller.
    function automatic logic arb_is_busy(input arb_state_t s);
        return (s == ARB_INST_BUSY) || (s == ARB_DATA_BUSY);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and controller bus bundle for the memory arbiter.
// slave  : arbiter side (drives completions and controller requests).
// master : environment side (fetch unit, load/store port and RAM controller).
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Fetch requester
    logic          inst_req_in;
    logic [AW-1:0] inst_addr_in;
    logic          inst_rdy_out;
    logic [DW-1:0] inst_data_out;
    // Load/store requester
    logic          data_req_in;
    logic          data_rw_in;
    logic          data_sgn_in;
    logic [2:0]    data_width_in;
    logic [AW-1:0] data_addr_in;
    logic [DW-1:0] data_wdata_in;
    logic          data_rdy_out;
    logic [DW-1:0] data_rdata_out;
    // RAM controller
    logic          ctrl_inst_en_out;
    logic [AW-1:0] ctrl_inst_addr_out;
    logic          ctrl_inst_rdy_in;
    logic [DW-1:0] ctrl_inst_in;
    logic          ctrl_data_en_out;
    logic          ctrl_data_rw_out;
    logic          ctrl_data_sgn_out;
    logic [2:0]    ctrl_data_width_out;
    logic [AW-1:0] ctrl_data_addr_out;
    logic [DW-1:0] ctrl_data_data_out;
    logic          ctrl_data_rdy_in;
    logic [DW-1:0] ctrl_data_in;

    modport slave (
        input  inst_req_in, inst_addr_in,
        input  data_req_in, data_rw_in, data_sgn_in, data_width_in,
        input  data_addr_in, data_wdata_in,
        input  ctrl_inst_rdy_in, ctrl_inst_in, ctrl_data_rdy_in, ctrl_data_in,
        output inst_rdy_out, inst_data_out, data_rdy_out, data_rdata_out,
        output ctrl_inst_en_out, ctrl_inst_addr_out,
        output ctrl_data_en_out, ctrl_data_rw_out, ctrl_data_sgn_out,
        output ctrl_data_width_out, ctrl_data_addr_out, ctrl_data_data_out
    );

    modport master (
        output inst_req_in, inst_addr_in,
        output data_req_in, data_rw_in, data_sgn_in, data_width_in,
        output data_addr_in, data_wdata_in,
        output ctrl_inst_rdy_in, ctrl_inst_in, ctrl_data_rdy_in, ctrl_data_in,
        input  inst_rdy_out, inst_data_out, data_rdy_out, data_rdata_out,
        input  ctrl_inst_en_out, ctrl_inst_addr_out,
        input  ctrl_data_en_out, ctrl_data_rw_out, ctrl_data_sgn_out,
        input  ctrl_data_width_out, ctrl_data_addr_out, ctrl_data_data_out
    );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive data grants made while a fetch waits.
// o_full tells the arbiter that fetch must win the next contention.
module mem_arb_starve_ctr #(
    parameter int MAX = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_full
);

    localparam int CW = $clog2(MAX + 1);

    logic [CW-1:0] r_cnt;

    // Clear wins over increment; the count sticks at MAX.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (i_clr) begin
                r_cnt <= '0;
            end else if (i_inc && !o_full) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_full = (r_cnt >= CW'(MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of the byte-serial RAM controller.
// Data has priority; fetch is guaranteed a grant after STARVE_MAX
// consecutive data grants. Granted fields are latched and held until the
// controller reports completion. Optional macro MEM_ARB_PERF_EN adds
// fetch/data/busy-cycle performance counters.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW         = AddressWidth,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          rdy_in,
    input  logic          flush_in,
    mem_arbiter_if.slave  bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]   perf_inst_cnt_out,
    output logic [31:0]   perf_data_cnt_out,
    output logic [31:0]   perf_busy_cnt_out
`endif
);

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic          w_inst_elig;
    logic          w_data_elig;
    logic          w_grant_inst;
    logic          w_grant_data;
    logic          w_starve_full;
    logic          w_starve_inc;
    logic          w_starve_clr;

    logic          r_drop;
    logic          r_inst_rdy;
    logic [DW-1:0] r_inst_data;
    logic          r_data_rdy;
    logic [DW-1:0] r_data_rdata;
    logic          r_ctrl_inst_en;
    logic [AW-1:0] r_ctrl_inst_addr;
    logic          r_ctrl_data_en;
    logic          r_ctrl_data_rw;
    logic          r_ctrl_data_sgn;
    logic [2:0]    r_ctrl_data_width;
    logic [AW-1:0] r_ctrl_data_addr;
    logic [DW-1:0] r_ctrl_data_wdata;

    assign w_inst_elig = bus.inst_req_in && !flush_in;
    assign w_data_elig = bus.data_req_in;

    // Grant decision and next state from the current state and requests.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        w_state_nxt  = r_state;
        w_grant_inst = 1'b0;
        w_grant_data = 1'b0;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_data_elig && (!w_inst_elig || !w_starve_full)) begin
                    w_grant_data = 1'b1;
                    w_state_nxt  = ARB_DATA_BUSY;
                end else if (w_inst_elig) begin
                    w_grant_inst = 1'b1;
                    w_state_nxt  = ARB_INST_BUSY;
                end
            end
            ARB_INST_BUSY: if (bus.ctrl_inst_rdy_in) w_state_nxt = ARB_RECOVER;
            ARB_DATA_BUSY: if (bus.ctrl_data_rdy_in) w_state_nxt = ARB_RECOVER;
            ARB_RECOVER:   w_state_nxt = ARB_IDLE;
            default:       w_state_nxt = ARB_IDLE;
        endcase
    end

    // Starvation bookkeeping only moves while arbitrating in IDLE.
    assign w_starve_inc = w_grant_data && bus.inst_req_in;
    assign w_starve_clr = (r_state == ARB_IDLE) && (w_grant_inst || !bus.inst_req_in);

    mem_arb_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .i_clk   (clk_in),
        .i_rst_n (rst_n_in),
        .i_en    (rdy_in),
        .i_inc   (w_starve_inc),
        .i_clr   (w_starve_clr),
        .o_full  (w_starve_full)
    );

    // State register; frozen while the global enable is low.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state <= ARB_IDLE;
        end else if (rdy_in) begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of block order.
            r_state <= w_state_nxt;
        end
    end

    // Latch granted fields, drive enables and produce completion pulses.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_drop            <= 1'b0;
            r_inst_rdy        <= 1'b0;
            r_inst_data       <= '0;
            r_data_rdy        <= 1'b0;
            r_data_rdata      <= '0;
            r_ctrl_inst_en    <= 1'b0;
            r_ctrl_inst_addr  <= '0;
            r_ctrl_data_en    <= 1'b0;
            r_ctrl_data_rw    <= 1'b0;
            r_ctrl_data_sgn   <= 1'b0;
            r_ctrl_data_width <= '0;
            r_ctrl_data_addr  <= '0;
            r_ctrl_data_wdata <= '0;
        end else if (rdy_in) begin
            if (w_grant_inst) begin
                r_ctrl_inst_en   <= 1'b1;
                r_ctrl_inst_addr <= bus.inst_addr_in;
            end
            if (w_grant_data) begin
                r_ctrl_data_en    <= 1'b1;
                r_ctrl_data_rw    <= bus.data_rw_in;
                r_ctrl_data_sgn   <= bus.data_sgn_in;
                r_ctrl_data_width <= bus.data_width_in;
                r_ctrl_data_addr  <= bus.data_addr_in;
                r_ctrl_data_wdata <= bus.data_wdata_in;
            end
            if (r_state == ARB_INST_BUSY) begin
                // The controller cannot abort, so a flush only marks the
                // result for discard; the completion clears the mark.
                if (bus.ctrl_inst_rdy_in) begin
                    r_ctrl_inst_en <= 1'b0;
                    r_inst_data    <= bus.ctrl_inst_in;
                    r_inst_rdy     <= !r_drop && !flush_in;
                    r_drop         <= 1'b0;
                end else if (flush_in) begin
                    r_drop <= 1'b1;
                end
            end
            if ((r_state == ARB_DATA_BUSY) && bus.ctrl_data_rdy_in) begin
                r_ctrl_data_en <= 1'b0;
                r_data_rdata   <= bus.ctrl_data_in;
                r_data_rdy     <= 1'b1;
            end
            if (r_state == ARB_RECOVER) begin
                r_inst_rdy <= 1'b0;
                r_data_rdy <= 1'b0;
            end
        end
    end

    assign bus.inst_rdy_out        = r_inst_rdy;
    assign bus.inst_data_out       = r_inst_data;
    assign bus.data_rdy_out        = r_data_rdy;
    assign bus.data_rdata_out      = r_data_rdata;
    assign bus.ctrl_inst_en_out    = r_ctrl_inst_en;
    assign bus.ctrl_inst_addr_out  = r_ctrl_inst_addr;
    assign bus.ctrl_data_en_out    = r_ctrl_data_en;
    assign bus.ctrl_data_rw_out    = r_ctrl_data_rw;
    assign bus.ctrl_data_sgn_out   = r_ctrl_data_sgn;
    assign bus.ctrl_data_width_out = r_ctrl_data_width;
    assign bus.ctrl_data_addr_out  = r_ctrl_data_addr;
    assign bus.ctrl_data_data_out  = r_ctrl_data_wdata;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] r_perf_inst;
    logic [31:0] r_perf_data;
    logic [31:0] r_perf_busy;

    // Free-running performance counters; wrap naturally at 2^32.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_perf_inst <= '0;
            r_perf_data <= '0;
            r_perf_busy <= '0;
        end else if (rdy_in) begin
            if ((r_state == ARB_INST_BUSY) && bus.ctrl_inst_rdy_in && !r_drop && !flush_in)
                r_perf_inst <= r_perf_inst + 32'd1;
            if ((r_state == ARB_DATA_BUSY) && bus.ctrl_data_rdy_in)
                r_perf_data <= r_perf_data + 32'd1;
            if (arb_is_busy(r_state))
                r_perf_busy <= r_perf_busy + 32'd1;
        end
    end

    assign perf_inst_cnt_out = r_perf_inst;
    assign perf_data_cnt_out = r_perf_data;
    assign perf_busy_cnt_out = r_perf_busy;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter. Inputs change and outputs
// are sampled on the falling edge; the DUT updates on the rising edge.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    logic rdy_in   = 1'b1;
    logic flush_in = 1'b0;

    int n_checks    = 0;
    int n_pass      = 0;
    int inst_pulses = 0;
    int data_pulses = 0;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_inst_cnt_out;
    logic [31:0] perf_data_cnt_out;
    logic [31:0] perf_busy_cnt_out;
`endif

    mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .rdy_in            (rdy_in),
        .flush_in          (flush_in),
        .bus               (bus)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_inst_cnt_out (perf_inst_cnt_out),
        .perf_data_cnt_out (perf_data_cnt_out),
        .perf_busy_cnt_out (perf_busy_cnt_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one clock and tally any completion pulses seen.
    task automatic cyc();
        @(negedge clk_in);
        if (bus.inst_rdy_out) inst_pulses++;
        if (bus.data_rdy_out) data_pulses++;
    endtask

    function automatic logic [1:0] st();
        return dut.r_state;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          data_grants;
        int          pulses0;
        logic        inst_seen;
        logic        prev_den;

        bus.inst_req_in      = 1'b0;
        bus.inst_addr_in     = '0;
        bus.data_req_in      = 1'b0;
        bus.data_rw_in       = 1'b0;
        bus.data_sgn_in      = 1'b0;
        bus.data_width_in    = '0;
        bus.data_addr_in     = '0;
        bus.data_wdata_in    = '0;
        bus.ctrl_inst_rdy_in = 1'b0;
        bus.ctrl_inst_in     = '0;
        bus.ctrl_data_rdy_in = 1'b0;
        bus.ctrl_data_in     = '0;

        // 1. Reset with both requests pending, then data wins first.
        @(negedge clk_in);
        bus.inst_req_in   = 1'b1;
        bus.inst_addr_in  = 32'h0000_0500;
        bus.data_req_in   = 1'b1;
        bus.data_rw_in    = 1'b1;
        bus.data_width_in = WIDTH_W;
        bus.data_addr_in  = 32'h0000_0100;
        repeat (3) cyc();
        check("rst_inst_en",  bus.ctrl_inst_en_out, 0);
        check("rst_data_en",  bus.ctrl_data_en_out, 0);
        check("rst_inst_rdy", bus.inst_rdy_out, 0);
        check("rst_data_rdy", bus.data_rdy_out, 0);
        check("rst_rdata",    bus.data_rdata_out, 0);
        check("rst_state",    st(), ARB_IDLE);
        rst_n_in = 1'b1;
        cyc();
        check("t1_data_en",   bus.ctrl_data_en_out, 1);
        check("t1_inst_en",   bus.ctrl_inst_en_out, 0);
        check("t1_data_addr", bus.ctrl_data_addr_out, 32'h0000_0100);
        check("t1_starve",    dut.u_starve.r_cnt, 1);
        bus.ctrl_data_in     = 32'h0000_0055;
        bus.ctrl_data_rdy_in = 1'b1;
        cyc();
        check("t1_data_rdy",  bus.data_rdy_out, 1);
        check("t1_rdata",     bus.data_rdata_out, 32'h55);
        bus.ctrl_data_rdy_in = 1'b0;
        bus.data_req_in      = 1'b0;
        bus.inst_req_in      = 1'b0;
        cyc();
        check("t1_rdy_clr",   bus.data_rdy_out, 0);
        check("t1_idle",      st(), ARB_IDLE);

        // 2. Lone fetch at 0x1000 returning 0xDEADBEEF.
        bus.inst_req_in  = 1'b1;
        bus.inst_addr_in = 32'h0000_1000;
        cyc();
        check("t2_inst_en",   bus.ctrl_inst_en_out, 1);
        check("t2_inst_addr", bus.ctrl_inst_addr_out, 32'h0000_1000);
        check("t2_busy",      st(), ARB_INST_BUSY);
        pulses0 = inst_pulses;
        bus.ctrl_inst_in     = 32'hDEAD_BEEF;
        bus.ctrl_inst_rdy_in = 1'b1;
        cyc();
        check("t2_inst_rdy",  bus.inst_rdy_out, 1);
        check("t2_inst_data", bus.inst_data_out, 32'hDEAD_BEEF);
        check("t2_en_drop",   bus.ctrl_inst_en_out, 0);
        check("t2_recover",   st(), ARB_RECOVER);
        bus.ctrl_inst_rdy_in = 1'b0;
        bus.inst_req_in      = 1'b0;
        cyc();
        check("t2_idle",      st(), ARB_IDLE);
        cyc();
        check("t2_one_pulse", inst_pulses - pulses0, 1);

        // 3. Contention: fetch held, data back-to-back; 4 data grants then fetch.
        bus.inst_req_in  = 1'b1;
        bus.inst_addr_in = 32'h0000_2000;
        bus.data_req_in  = 1'b1;
        data_grants = 0;
        inst_seen   = 1'b0;
        prev_den    = 1'b0;
        for (int i = 0; i < 60 && !inst_seen; i++) begin
            cyc();
            if (bus.ctrl_data_en_out && !prev_den) data_grants++;
            prev_den = bus.ctrl_data_en_out;
            if (bus.ctrl_inst_en_out) inst_seen = 1'b1;
            bus.ctrl_data_rdy_in = bus.ctrl_data_en_out;
        end
        check("t3_inst_granted", inst_seen, 1);
        check("t3_data_grants",  data_grants, 4);
        check("t3_starve_clr",   dut.u_starve.r_cnt, 0);
        check("t3_inst_addr",    bus.ctrl_inst_addr_out, 32'h0000_2000);
        bus.ctrl_data_rdy_in = 1'b0;
        bus.data_req_in      = 1'b0;
        bus.ctrl_inst_in     = 32'h1234_5678;
        bus.ctrl_inst_rdy_in = 1'b1;
        cyc();
        check("t3_inst_rdy",  bus.inst_rdy_out, 1);
        check("t3_inst_data", bus.inst_data_out, 32'h1234_5678);
        bus.ctrl_inst_rdy_in = 1'b0;
        bus.inst_req_in      = 1'b0;
        cyc();

        // 4. Flush two cycles after a fetch grant drops the result.
        bus.inst_req_in  = 1'b1;
        bus.inst_addr_in = 32'h0000_3000;
        cyc();
        check("t4_inst_en",  bus.ctrl_inst_en_out, 1);
        pulses0 = inst_pulses;
        cyc();
        flush_in        = 1'b1;
        bus.inst_req_in = 1'b0;
        cyc();
        flush_in = 1'b0;
        check("t4_en_hold1", bus.ctrl_inst_en_out, 1);
        cyc();
        check("t4_en_hold2", bus.ctrl_inst_en_out, 1);
        bus.ctrl_inst_in     = 32'h0000_0BAD;
        bus.ctrl_inst_rdy_in = 1'b1;
        cyc();
        check("t4_en_off",   bus.ctrl_inst_en_out, 0);
        check("t4_recover",  st(), ARB_RECOVER);
        check("t4_data_upd", bus.inst_data_out, 32'h0000_0BAD);
        bus.ctrl_inst_rdy_in = 1'b0;
        cyc();
        check("t4_no_pulse", inst_pulses - pulses0, 0);
        bus.data_req_in   = 1'b1;
        bus.data_rw_in    = 1'b0;
        bus.data_width_in = WIDTH_W;
        bus.data_addr_in  = 32'h0000_0040;
        bus.data_wdata_in = 32'hCAFE_F00D;
        cyc();
        check("t4_data_en",    bus.ctrl_data_en_out, 1);
        check("t4_data_wdata", bus.ctrl_data_data_out, 32'hCAFE_F00D);
        check("t4_data_rw",    bus.ctrl_data_rw_out, 0);
        bus.ctrl_data_rdy_in = 1'b1;
        cyc();
        check("t4_data_rdy",   bus.data_rdy_out, 1);
        bus.ctrl_data_rdy_in = 1'b0;
        bus.data_req_in      = 1'b0;
        cyc();

        // 5. Signed byte load; fields stay latched while inputs move.
        bus.data_req_in   = 1'b1;
        bus.data_rw_in    = 1'b1;
        bus.data_sgn_in   = 1'b1;
        bus.data_width_in = WIDTH_B;
        bus.data_addr_in  = 32'h0002_0000;
        cyc();
        check("t5_width", bus.ctrl_data_width_out, 3'b001);
        check("t5_sgn",   bus.ctrl_data_sgn_out, 1);
        bus.data_rw_in       = 1'b0;
        bus.data_sgn_in      = 1'b0;
        bus.data_width_in    = WIDTH_H;
        bus.data_addr_in     = 32'h0000_FFFF;
        bus.ctrl_inst_in     = 32'h9999_9999;
        bus.ctrl_inst_rdy_in = 1'b1;
        pulses0 = inst_pulses;
        cyc();
        check("t5_width_hold", bus.ctrl_data_width_out, 3'b001);
        check("t5_addr_hold",  bus.ctrl_data_addr_out, 32'h0002_0000);
        check("t5_rw_hold",    bus.ctrl_data_rw_out, 1);
        check("t5_sgn_hold",   bus.ctrl_data_sgn_out, 1);
        check("t5_busy",       st(), ARB_DATA_BUSY);
        check("t5_ignore_inst", inst_pulses - pulses0, 0);
        bus.ctrl_inst_rdy_in = 1'b0;
        bus.ctrl_data_in     = 32'hFFFF_FF80;
        bus.ctrl_data_rdy_in = 1'b1;
        cyc();
        check("t5_rdy",       bus.data_rdy_out, 1);
        check("t5_rdata",     bus.data_rdata_out, 32'hFFFF_FF80);
        check("t5_inst_data", bus.inst_data_out, 32'h0000_0BAD);
        bus.ctrl_data_rdy_in = 1'b0;
        bus.data_req_in      = 1'b0;
        cyc();

        // 6. Global enable low freezes a completing data transfer.
        bus.data_req_in   = 1'b1;
        bus.data_rw_in    = 1'b0;
        bus.data_width_in = WIDTH_W;
        bus.data_addr_in  = 32'h0000_0080;
        cyc();
        check("t6_data_en", bus.ctrl_data_en_out, 1);
        rdy_in               = 1'b0;
        bus.ctrl_data_in     = 32'h0000_0077;
        bus.ctrl_data_rdy_in = 1'b1;
        pulses0 = data_pulses;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("t6_frozen_state", st(), ARB_DATA_BUSY);
        end
        check("t6_no_pulse", data_pulses - pulses0, 0);
        check("t6_en_held",  bus.ctrl_data_en_out, 1);
        rdy_in = 1'b1;
        cyc();
        check("t6_rdy",     bus.data_rdy_out, 1);
        check("t6_rdata",   bus.data_rdata_out, 32'h77);
        check("t6_recover", st(), ARB_RECOVER);
        bus.ctrl_data_rdy_in = 1'b0;
        bus.data_req_in      = 1'b0;
        cyc();
        check("t6_rdy_clr",   bus.data_rdy_out, 0);
        check("t6_one_pulse", data_pulses - pulses0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
